mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous memory between the processor's instruction-fetch port and its data port. The block sits between the core and a unified 32-bit, word-addressed memory. It serializes the two requesters with a registered command and a one-cycle memory read latency. Ties are resolved round-robin or by fixed data priority.

## Interface
Parameters:
- `ADDR_W`, default 32: address width (word addresses).
- `DATA_W`, default 32: data width.
- `RR`, default 1: 1 selects round-robin on ties; 0 makes the data port always win ties.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ifReq` input 1: fetch request; held until `ifValid`.
- `ifAddr` input `ADDR_W`: fetch address; held stable while `ifReq` is high.
- `ifData` output `DATA_W`: fetched word; meaningful only while `ifValid` is high.
- `ifValid` output 1: one-cycle completion pulse for the fetch.
- `dReq` input 1: data request; held until `dValid`.
- `dWE` input 1: 1 = store, 0 = load; held with `dReq`.
- `dAddr` input `ADDR_W`: data address.
- `dWData` input `DATA_W`: store data.
- `dRData` output `DATA_W`: load data; meaningful only while `dValid` is high.
- `dValid` output 1: one-cycle completion pulse (loads and stores).
- `memAddr` output `ADDR_W`: registered memory address.
- `memWData` output `DATA_W`: registered write data.
- `memWE` output 1: registered write enable.
- `memRE` output 1: registered read enable.
- `memRData` input `DATA_W`: read data, valid the cycle after `memRE`.

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: command is on the memory bus.
  - RESP: memory result cycle.
- IDLE:
  - Samples `ifReq` and `dReq`.
  - If either is high, latches the winner's address, data and direction into the command registers, sets `owner`, and moves to ACCESS.
  - Otherwise stays in IDLE.
- Arbitration:
  - A single requester always wins.
  - Ties with `RR`=1: the requester that is not `lastGrant` wins.
  - Ties with `RR`=0: the data port wins.
  - `lastGrant` updates on every grant.
- ACCESS:
  - `memAddr`, `memWData`, `memWE` and `memRE` are driven from the registers.
  - A fetch sets `memRE`=1 and `memWE`=0.
  - A load sets `memRE`=1 and `memWE`=0.
  - A store sets `memWE`=1 and `memRE`=0.
  - Always moves to RESP.
- RESP:
  - `memWE` and `memRE` are 0.
  - The owner's valid is high.
  - `ifData` and `dRData` pass `memRData` through combinationally.
  - A store also pulses `dValid`; `dRData` is don't-care in that case.
  - Arbitration runs with the owner's request masked, because the owner is still holding `req` this cycle. If the other port is requesting, it is granted and the state moves directly to ACCESS; otherwise the state moves to IDLE.
- The address of a completed request must not be reissued.
- A requester deasserts or changes `req` and address only in the cycle after its valid.

## Timing
- Reset values:
  - state = IDLE.
  - `lastGrant` = data, so the first tie goes to fetch when `RR`=1.
  - `memWE`, `memRE`, `ifValid`, `dValid` = 0.
  - `memAddr`, `memWData`, `owner` = 0.
- Reset is asynchronous. Asserting it mid-access drops `memWE` and `memRE` immediately. A store whose ACCESS cycle has not reached its closing edge is not performed. No valid is issued for the aborted request.
- Latency: a request first sampled at edge E0 has its command on the bus after E0. Valid is high in the cycle after edge E1. That is 2 cycles from sampled request to valid.
- Throughput: 1 access per 2 cycles with no idle gaps under continuous contention.
- Valid pulses last exactly one cycle. `ifValid` and `dValid` are never high together.
- A request that drops before its grant is simply not served. A request that drops after its grant still completes its memory access.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, ACCESS, RESP}.
  - owner constants OWN_IF=0 and OWN_D=1.
- Sub-module `rr_pick2`: combinational 2-input grant picker. Inputs: `req[1:0]`, `mask[1:0]`, `last`, `RR`. Outputs: `grant` and `any`.

## Test plan
- Fetch alone: `ifReq`=1 with `ifAddr`=0x10 and memory[0x10]=0xDEADBEEF → `memRE`=1 and `memAddr`=0x10 in cycle 1; `ifValid`=1 and `ifData`=0xDEADBEEF in cycle 2; state back to IDLE.
- Store then load: `dWE`=1, `dAddr`=0x20, `dWData`=0x12345678 → `memWE` pulses once and `dValid` pulses in cycle 2. Follow with a load from 0x20 → `dRData`=0x12345678.
- Tie after reset with `RR`=1: both ports request → fetch is served first, and data is granted directly from RESP with `dValid` 2 cycles after `ifValid`. Sustained ties alternate grants IF, D, IF, D.
- `RR`=0 with both ports held high for 6 cycles → the data port wins every tie.
- Reset asserted during the ACCESS cycle of a store to 0x30 → `memWE` drops immediately, memory[0x30] is unchanged, and no `dValid` is issued. After release the FSM is in IDLE and serves the next request normally.
- Request withdrawn before grant: `dReq` pulses for one cycle while a fetch is in ACCESS → no data access is issued and no `dValid` appears.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arbState_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way grant picker: masked requests, tie broken round-robin or toward data.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  input  logic       RR,
  output logic       grant,
  output logic       any
);
  logic [1:0] eff;

  assign eff = req & ~mask;
  assign any = |eff;

  always_comb begin
    grant = eff[1] ? OWN_D : OWN_IF;
    if (&eff) grant = RR ? ~last : OWN_D;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and data requests onto one single-port memory
// with a registered command and one-cycle read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifValid,
  input  logic              dReq,
  input  logic              dWE,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dValid,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWE,
  output logic              memRE,
  input  logic [DATA_W-1:0] memRData
);
  arbState_t  state;
  logic       owner;
  logic       lastGrant;
  logic [1:0] reqVec;
  logic [1:0] maskVec;
  logic       grant;
  logic       anyReq;
  logic       isStore;

  assign ifData = memRData;
  assign dRData = memRData;

  // The owner still holds its request during RESP, so hide it from the picker.
  assign reqVec  = {dReq, ifReq};
  assign maskVec = (state == RESP) ? ((owner == OWN_D) ? 2'b10 : 2'b01) : 2'b00;
  assign isStore = (grant == OWN_D) && dWE;

  rr_pick2 picker (
    .req  (reqVec),
    .mask (maskVec),
    .last (lastGrant),
    .RR   (RR != 0),
    .grant(grant),
    .any  (anyReq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lastGrant <= OWN_D;
      memAddr   <= '0;
      memWData  <= '0;
      memWE     <= 1'b0;
      memRE     <= 1'b0;
      ifValid   <= 1'b0;
      dValid    <= 1'b0;
    end else begin
      ifValid <= 1'b0;
      dValid  <= 1'b0;
      memWE   <= 1'b0;
      memRE   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (anyReq) begin
            state     <= ACCESS;
            owner     <= grant;
            lastGrant <= grant;
            memAddr   <= (grant == OWN_D) ? dAddr : ifAddr;
            memWData  <= (grant == OWN_D) ? dWData : '0;
            memWE     <= isStore;
            memRE     <= !isStore;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner == OWN_D) dValid <= 1'b1;
          else                ifValid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (round-robin and data-priority) on shared stimulus.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifReq = 1'b0, dReq = 1'b0, dWE = 1'b0;
  logic [31:0] ifAddr = '0, dAddr = '0, dWData = '0;
  logic [31:0] ifData, dRData, memAddr, memWData, memRData;
  logic        ifValid, dValid, memWE, memRE;
  logic [31:0] ifData0, dRData0, memAddr0, memWData0, memRData0;
  logic        ifValid0, dValid0, memWE0, memRE0;
  logic        tbWr = 1'b0;
  logic [7:0]  tbAddr = '0;
  logic [31:0] tbData = '0;
  logic [31:0] mem  [0:255];
  logic [31:0] mem0 [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1)) dut (
    .clk(clk), .reset(reset), .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData),
    .ifValid(ifValid), .dReq(dReq), .dWE(dWE), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData), .dValid(dValid), .memAddr(memAddr), .memWData(memWData),
    .memWE(memWE), .memRE(memRE), .memRData(memRData));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(0)) dut0 (
    .clk(clk), .reset(reset), .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData0),
    .ifValid(ifValid0), .dReq(dReq), .dWE(dWE), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData0), .dValid(dValid0), .memAddr(memAddr0), .memWData(memWData0),
    .memWE(memWE0), .memRE(memRE0), .memRData(memRData0));

  // Single-port synchronous memories with a bench-side preload port.
  always @(posedge clk) begin
    if (memWE) mem[memAddr[7:0]] <= memWData;
    else if (tbWr) mem[tbAddr] <= tbData;
    if (memRE) memRData <= mem[memAddr[7:0]];
  end

  always @(posedge clk) begin
    if (memWE0) mem0[memAddr0[7:0]] <= memWData0;
    else if (tbWr) mem0[tbAddr] <= tbData;
    if (memRE0) memRData0 <= mem0[memAddr0[7:0]];
  end

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dWE;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [3:0]  eCtl;   // {memWE, memRE, ifValid, dValid} after the edge
    logic [31:0] eAddr;
    logic [31:0] eData;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic we, input logic [31:0] da, input logic [31:0] wd,
                              input logic [3:0] ctl, input logic [31:0] ea,
                              input logic [31:0] ed);
    vec_t v;
    v.ifReq = ir; v.ifAddr = ia; v.dReq = dr; v.dWE = we; v.dAddr = da;
    v.dWData = wd; v.eCtl = ctl; v.eAddr = ea; v.eData = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    tbWr = 1'b1; tbAddr = a; tbData = d;
    @(posedge clk); #1;
    tbWr = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic pulseReset;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = mk(1, 32'h10, 0, 0, 0, 0,             4'b0100, 32'h10, 0);
    vecs[1] = mk(1, 32'h10, 0, 0, 0, 0,             4'b0010, 0, 32'hDEADBEEF);
    vecs[2] = mk(1, 32'h10, 0, 0, 0, 0,             4'b0000, 0, 0);
    vecs[3] = mk(0, 0,      0, 0, 0, 0,             4'b0000, 0, 0);
    vecs[4] = mk(0, 0, 1, 1, 32'h20, 32'h12345678,  4'b1000, 32'h20, 0);
    vecs[5] = mk(0, 0, 1, 1, 32'h20, 32'h12345678,  4'b0001, 0, 0);
    vecs[6] = mk(0, 0, 1, 1, 32'h20, 32'h12345678,  4'b0000, 0, 0);
    vecs[7] = mk(0, 0, 1, 0, 32'h20, 0,             4'b0100, 32'h20, 0);
    vecs[8] = mk(0, 0, 1, 0, 32'h20, 0,             4'b0001, 0, 32'h12345678);
    vecs[9] = mk(0, 0, 0, 0, 0, 0,                  4'b0000, 0, 0);

    // Reset state, with memories preloaded while reset is held.
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h30, 32'hA5A5A5A5);
    chk("rst_ctl",   {28'd0, memWE, memRE, ifValid, dValid}, 32'd0);
    chk("rst_addr",  memAddr, 32'd0);
    chk("rst_wdata", memWData, 32'd0);
    chk("rst_ctl0",  {28'd0, memWE0, memRE0, ifValid0, dValid0}, 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      ifReq = vecs[i].ifReq; ifAddr = vecs[i].ifAddr; dReq = vecs[i].dReq;
      dWE = vecs[i].dWE; dAddr = vecs[i].dAddr; dWData = vecs[i].dWData;
      step();
      chk($sformatf("vec%0d_ctl", i), {28'd0, memWE, memRE, ifValid, dValid},
          {28'd0, vecs[i].eCtl});
      if (vecs[i].eCtl[3] | vecs[i].eCtl[2])
        chk($sformatf("vec%0d_addr", i), memAddr, vecs[i].eAddr);
      if (vecs[i].eCtl[3])
        chk($sformatf("vec%0d_wdata", i), memWData, vecs[i].dWData);
      if (vecs[i].eCtl[1])
        chk($sformatf("vec%0d_ifdata", i), ifData, vecs[i].eData);
      if (vecs[i].eCtl[0] && !vecs[i].dWE)
        chk($sformatf("vec%0d_drdata", i), dRData, vecs[i].eData);
    end

    // Sustained tie from reset: RR=1 serves IF first, RR=0 serves D first.
    pulseReset();
    ifReq = 1; ifAddr = 32'h10; dReq = 1; dWE = 0; dAddr = 32'h20;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tie%0d_if", k),   {31'd0, ifValid},  {31'd0, k % 4 == 2});
      chk($sformatf("tie%0d_d", k),    {31'd0, dValid},   {31'd0, k % 4 == 0});
      chk($sformatf("tie%0d_if0", k),  {31'd0, ifValid0}, {31'd0, k % 4 == 0});
      chk($sformatf("tie%0d_d0", k),   {31'd0, dValid0},  {31'd0, k % 4 == 2});
      if (k % 4 == 2) begin
        chk($sformatf("tie%0d_ifdata", k), ifData, 32'hDEADBEEF);
        chk($sformatf("tie%0d_drdata0", k), dRData0, 32'h12345678);
      end
      if (k % 4 == 0) chk($sformatf("tie%0d_drdata", k), dRData, 32'h12345678);
    end
    ifReq = 0; dReq = 0;
    step();
    chk("tie_idle",  {28'd0, memWE, memRE, ifValid, dValid}, 32'd0);
    chk("tie_idle0", {28'd0, memWE0, memRE0, ifValid0, dValid0}, 32'd0);
    // Fresh tie from IDLE: round-robin last granted D, fixed priority always D.
    ifReq = 1; dReq = 1;
    step();
    chk("tie2_addr",  memAddr,  32'h10);
    chk("tie2_addr0", memAddr0, 32'h20);
    ifReq = 0; dReq = 0;
    step();
    chk("tie2_late_if", {31'd0, ifValid},  32'd1);
    chk("tie2_late_d0", {31'd0, dValid0}, 32'd1);
    step();

    // Reset during the ACCESS cycle of a store aborts it.
    dReq = 1; dWE = 1; dAddr = 32'h30; dWData = 32'h0BADF00D;
    step();
    chk("abort_we", {31'd0, memWE}, 32'd1);
    chk("abort_addr", memAddr, 32'h30);
    reset = 1'b0;
    #1;
    chk("abort_drop", {30'd0, memWE, memRE}, 32'd0);
    step();
    dReq = 0; dWE = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("abort_quiet%0d", k), {28'd0, memWE, memRE, ifValid, dValid}, 32'd0);
    end
    chk("abort_mem", mem[8'h30], 32'hA5A5A5A5);
    ifReq = 1; ifAddr = 32'h10;
    step();
    chk("post_rst_ctl", {28'd0, memWE, memRE, ifValid, dValid}, 32'b0100);
    step();
    chk("post_rst_valid", {28'd0, memWE, memRE, ifValid, dValid}, 32'b0010);
    chk("post_rst_data", ifData, 32'hDEADBEEF);
    step();
    ifReq = 0;
    step();

    // Data request withdrawn while a fetch is in ACCESS is never served.
    ifReq = 1; ifAddr = 32'h10;
    step();
    dReq = 1; dWE = 0; dAddr = 32'h40;
    step();
    chk("wd_ifvalid", {31'd0, ifValid}, 32'd1);
    dReq = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) ifReq = 0;
      chk($sformatf("wd_quiet%0d", k), {28'd0, memWE, memRE, ifValid, dValid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
